msg_pad_writer: RTL and testbench

Byte-stream front end that packs message bytes big-endian into 32-bit words, applies SHA-256 padding, and writes the result into the message word memory. The read-side address counter later walks this memory. The writer is the producing end of that memory interface. It asserts `write_complete` once the padded message, a whole number of 512-bit blocks, is in memory, and it reports the block count to the hash controller.

---
 rtl/sha256_pkg.sv | 17 +
 rtl/byte_packer.sv | 46 ++++
 rtl/msg_pad_writer.sv | 174 +++++++++++++++++
 tb/tb_msg_pad_writer.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/sha256_pkg.sv
// Shared constants and state type for the SHA-256 message front end.
package sha256_pkg;

   localparam int WORDS_PER_BLOCK = 16;
   localparam logic [7:0] PAD_BYTE = 8'h80;
   localparam int LEN_WORDS = 2;

   typedef enum logic [2:0] {
      S_IDLE,
      S_DATA,
      S_PAD,
      S_LEN_HI,
      S_LEN_LO,
      S_DONE
   } pad_state_t;

endpackage

// File: rtl/byte_packer.sv
// Big-endian byte packer; offers the word a byte would complete,
// with the 0x80 marker and zero fill folded in for a short last word.
module byte_packer
   import sha256_pkg::*;
(
   input  logic        clock,
   input  logic        reset,
   input  logic        clear,
   input  logic        shift,
   input  logic [7:0]  data,
   input  logic        last,
   output logic [31:0] word,
   output logic        full
);

   logic [23:0] sh;
   logic [1:0]  idx;

   assign full = (idx == 2'd3);

   always_comb begin
      word = '0;
      unique case (idx)
         2'd0: word = {data, PAD_BYTE, 16'h0000};
         2'd1: word = {sh[7:0], data, PAD_BYTE, 8'h00};
         2'd2: word = {sh[15:0], data, PAD_BYTE};
         2'd3: word = {sh, data};
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset || clear) begin
         sh  <= '0;
         idx <= '0;
      end else if (shift) begin
         if (full || last) begin
            sh  <= '0;
            idx <= '0;
         end else begin
            sh  <= {sh[15:0], data};
            idx <= idx + 2'd1;
         end
      end
   end

endmodule

// File: rtl/msg_pad_writer.sv
// Packs a byte stream into words, appends SHA-256 padding and length,
// and writes the padded blocks into message word memory.
module msg_pad_writer
   import sha256_pkg::*;
#(
   parameter  int MAX_MESSAGE_LENGTH = 64,
   localparam int AW = $clog2(MAX_MESSAGE_LENGTH)
) (
   input  logic          clock,
   input  logic          reset,
   input  logic          start,
   input  logic          in_valid,
   input  logic [7:0]    in_data,
   input  logic          in_last,
   output logic          in_ready,
   output logic          write_enable,
   output logic [AW-1:0] write_address,
   output logic [31:0]   write_data,
   output logic [AW-4:0] block_count,
   output logic          write_complete,
   output logic          overflow
);

   localparam int BW       = AW + 2;
   localparam int BLK_BITS = $clog2(WORDS_PER_BLOCK);
   localparam int LIMIT    = MAX_MESSAGE_LENGTH * 4 - 9;
   localparam logic [BLK_BITS-1:0] LEN_SLOT =
      BLK_BITS'(WORDS_PER_BLOCK - LEN_WORDS);

   pad_state_t    state, state_n;
   logic [AW:0]   ptr, ptr_n, ptr_inc;
   logic [BW-1:0] bytes, bytes_n, bytes_inc;
   logic          pad_first, pad_first_n;
   logic          in_ready_n, we_n, wc_n, ovf_n;
   logic [AW-1:0] addr_n;
   logic [31:0]   data_n, wdata;
   logic [AW-4:0] bc_n;
   logic          do_write, accept, at_len;
   logic          pk_clear, pk_shift, pk_full;
   logic [31:0]   pk_word;

   byte_packer u_packer (
      .clock (clock),
      .reset (reset),
      .clear (pk_clear),
      .shift (pk_shift),
      .data  (in_data),
      .last  (in_last),
      .word  (pk_word),
      .full  (pk_full)
   );

   assign ptr_inc   = ptr + 1'b1;
   assign bytes_inc = bytes + 1'b1;
   assign at_len    = (ptr_inc[BLK_BITS-1:0] == LEN_SLOT);
   assign accept    = (state == S_DATA) && in_valid && in_ready;

   always_comb begin
      state_n     = state;
      ptr_n       = ptr;
      bytes_n     = bytes;
      pad_first_n = pad_first;
      in_ready_n  = 1'b0;
      we_n        = 1'b0;
      addr_n      = '0;
      data_n      = '0;
      wc_n        = 1'b0;
      ovf_n       = overflow;
      bc_n        = block_count;
      do_write    = 1'b0;
      wdata       = '0;
      pk_clear    = 1'b0;
      pk_shift    = 1'b0;
      if (!start) begin
         state_n     = S_IDLE;
         ptr_n       = '0;
         bytes_n     = '0;
         pad_first_n = 1'b0;
         ovf_n       = 1'b0;
         bc_n        = '0;
         pk_clear    = 1'b1;
      end else begin
         unique case (state)
            S_IDLE: begin
               ptr_n       = '0;
               bytes_n     = '0;
               pad_first_n = 1'b0;
               ovf_n       = 1'b0;
               bc_n        = '0;
               pk_clear    = 1'b1;
               in_ready_n  = 1'b1;
               state_n     = S_DATA;
            end
            S_DATA: begin
               in_ready_n = 1'b1;
               if (accept) begin
                  pk_shift = 1'b1;
                  bytes_n  = bytes_inc;
                  do_write = pk_full || in_last;
                  wdata    = pk_word;
                  if (in_last) begin
                     in_ready_n = 1'b0;
                     // A full last word leaves the 0x80 marker for PAD
                     if (pk_full) begin
                        pad_first_n = 1'b1;
                        state_n     = S_PAD;
                     end else begin
                        state_n = at_len ? S_LEN_HI : S_PAD;
                     end
                  end else if (bytes_inc == BW'(LIMIT)) begin
                     in_ready_n = 1'b0;
                     ovf_n      = 1'b1;
                     state_n    = S_DONE;
                  end
               end
            end
            S_PAD: begin
               do_write    = 1'b1;
               wdata       = pad_first ? {PAD_BYTE, 24'h0} : 32'h0;
               pad_first_n = 1'b0;
               state_n     = at_len ? S_LEN_HI : S_PAD;
            end
            S_LEN_HI: begin
               do_write = 1'b1;
               state_n  = S_LEN_LO;
            end
            S_LEN_LO: begin
               do_write = 1'b1;
               wdata    = {{(32-BW-3){1'b0}}, bytes, 3'b000};
               state_n  = S_DONE;
            end
            S_DONE: begin
               wc_n = !overflow;
               bc_n = overflow ? '0 : ptr[AW:BLK_BITS];
            end
         endcase
      end
      if (do_write) begin
         we_n   = 1'b1;
         addr_n = ptr[AW-1:0];
         data_n = wdata;
         ptr_n  = ptr_inc;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state          <= S_IDLE;
         ptr            <= '0;
         bytes          <= '0;
         pad_first      <= 1'b0;
         in_ready       <= 1'b0;
         write_enable   <= 1'b0;
         write_address  <= '0;
         write_data     <= '0;
         block_count    <= '0;
         write_complete <= 1'b0;
         overflow       <= 1'b0;
      end else begin
         state          <= state_n;
         ptr            <= ptr_n;
         bytes          <= bytes_n;
         pad_first      <= pad_first_n;
         in_ready       <= in_ready_n;
         write_enable   <= we_n;
         write_address  <= addr_n;
         write_data     <= data_n;
         block_count    <= bc_n;
         write_complete <= wc_n;
         overflow       <= ovf_n;
      end
   end

endmodule

// File: tb/tb_msg_pad_writer.sv
// Randomized bench for msg_pad_writer against a byte-level
// SHA-256 padding model.
module tb_msg_pad_writer;

   localparam int MAX = 64;
   localparam int AW  = $clog2(MAX);

   typedef logic [7:0]  bq_t[$];
   typedef logic [31:0] wq_t[$];
   typedef struct {
      logic [AW-1:0] a;
      logic [31:0]   d;
      int            c;
   } wr_t;

   logic          clock = 1'b0;
   logic          reset;
   logic          start;
   logic          in_valid;
   logic [7:0]    in_data;
   logic          in_last;
   logic          in_ready;
   logic          write_enable;
   logic [AW-1:0] write_address;
   logic [31:0]   write_data;
   logic [AW-4:0] block_count;
   logic          write_complete;
   logic          overflow;

   int  compared   = 0;
   int  mismatched = 0;
   int  cyc        = 0;
   wr_t wlog[$];

   msg_pad_writer #(.MAX_MESSAGE_LENGTH(MAX)) dut (
      .clock          (clock),
      .reset          (reset),
      .start          (start),
      .in_valid       (in_valid),
      .in_data        (in_data),
      .in_last        (in_last),
      .in_ready       (in_ready),
      .write_enable   (write_enable),
      .write_address  (write_address),
      .write_data     (write_data),
      .block_count    (block_count),
      .write_complete (write_complete),
      .overflow       (overflow)
   );

   always #5 clock = ~clock;

   always @(posedge clock) cyc <= cyc + 1;

   always @(negedge clock) begin
      if (write_enable === 1'b1) begin
         wr_t e;
         e.a = write_address;
         e.d = write_data;
         e.c = cyc;
         wlog.push_back(e);
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: observed no finish expected finish");
      $fatal(1, "timeout");
   end

   task automatic check(input string tag, input logic [31:0] obs,
                        input logic [31:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic void build_ref(input bq_t msg, output wq_t w);
      bq_t p;
      logic [63:0] len;
      p   = msg;
      len = 64'(msg.size()) * 64'd8;
      p.push_back(8'h80);
      while (p.size() % 64 != 56) p.push_back(8'h00);
      for (int i = 7; i >= 0; i--) p.push_back(len[8*i +: 8]);
      w = {};
      for (int i = 0; i < p.size(); i += 4)
         w.push_back({p[i], p[i+1], p[i+2], p[i+3]});
   endfunction

   function automatic bq_t rand_msg(input int n);
      bq_t m;
      m = {};
      for (int i = 0; i < n; i++) m.push_back(8'($urandom));
      return m;
   endfunction

   task automatic send(input bq_t msg, input bit with_last,
                       input int mode, output bit ok);
      bit tog;
      tog = 1'b0;
      ok  = 1'b1;
      for (int i = 0; i < msg.size(); i++) begin
         bit done;
         int guard;
         done  = 1'b0;
         guard = 0;
         while (!done) begin
            bit stall;
            @(negedge clock);
            stall = (mode == 1) ? 1'($urandom_range(0, 1)) :
                    (mode == 2) ? tog : 1'b0;
            tog = ~tog;
            if (stall) begin
               in_valid = 1'b0;
               in_last  = 1'b0;
            end else begin
               in_valid = 1'b1;
               in_data  = msg[i];
               in_last  = with_last && (i == msg.size() - 1);
               if (in_ready === 1'b1) done = 1'b1;
            end
            guard++;
            if (!done && guard > 50) begin
               ok       = 1'b0;
               in_valid = 1'b0;
               in_last  = 1'b0;
               return;
            end
         end
      end
      @(negedge clock);
      in_valid = 1'b0;
      in_last  = 1'b0;
   endtask

   task automatic check_writes(input string name, input int base,
                               input wq_t r);
      int n, nw;
      n  = r.size();
      nw = wlog.size() - base;
      check({name, "_nwrites"}, 32'(nw), 32'(n));
      for (int k = 0; k < n && k < nw; k++) begin
         check($sformatf("%s_addr%0d", name, k),
               32'(wlog[base+k].a), 32'(k));
         check($sformatf("%s_word%0d", name, k), wlog[base+k].d, r[k]);
      end
   endtask

   task automatic run_msg(input string name, input bq_t msg,
                          input int mode);
      wq_t r;
      int  base, wcc;
      bit  ok, seen;
      build_ref(msg, r);
      base = wlog.size();
      @(negedge clock);
      start = 1'b1;
      send(msg, 1'b1, mode, ok);
      check({name, "_accept"}, 32'(ok), 32'd1);
      check({name, "_rdy_drop"}, 32'(in_ready), 32'd0);
      seen = 1'b0;
      wcc  = 0;
      for (int t = 0; t < 200 && !seen; t++) begin
         @(negedge clock);
         if (write_complete === 1'b1) begin
            seen = 1'b1;
            wcc  = cyc;
         end
      end
      check_writes(name, base, r);
      check({name, "_wc_seen"}, 32'(seen), 32'd1);
      if (seen && wlog.size() > base)
         check({name, "_wc_lat"}, 32'(wcc - wlog[wlog.size()-1].c), 32'd1);
      check({name, "_blocks"}, 32'(block_count), 32'(r.size() / 16));
      check({name, "_ovf"}, 32'(overflow), 32'd0);
      @(negedge clock);
      start = 1'b0;
      @(negedge clock);
      check({name, "_wc_clear"}, 32'(write_complete), 32'd0);
      check({name, "_bc_clear"}, 32'(block_count), 32'd0);
   endtask

   initial begin
      bq_t m;
      wq_t r;
      bit  ok;
      int  base;
      reset    = 1'b1;
      start    = 1'b0;
      in_valid = 1'b0;
      in_data  = '0;
      in_last  = 1'b0;
      repeat (3) @(negedge clock);
      check("rst_in_ready", 32'(in_ready), 32'd0);
      check("rst_we", 32'(write_enable), 32'd0);
      check("rst_addr", 32'(write_address), 32'd0);
      check("rst_data", write_data, 32'd0);
      check("rst_bc", 32'(block_count), 32'd0);
      check("rst_wc", 32'(write_complete), 32'd0);
      check("rst_ovf", 32'(overflow), 32'd0);
      reset = 1'b0;
      @(negedge clock);

      m = {8'h61, 8'h62, 8'h63};
      run_msg("abc", m, 0);
      m = {8'h61, 8'h62, 8'h63, 8'h64};
      run_msg("abcd", m, 0);
      run_msg("len56", rand_msg(56), 0);
      run_msg("len55", rand_msg(55), 1);
      run_msg("len247", rand_msg(247), 0);
      m = {8'h61, 8'h62, 8'h63};
      run_msg("abc_toggle", m, 2);
      for (int i = 0; i < 5; i++)
         run_msg($sformatf("rnd%0d", i),
                 rand_msg($urandom_range(1, 247)), 1);

      m    = rand_msg(247);
      base = wlog.size();
      @(negedge clock);
      start = 1'b1;
      send(m, 1'b0, 0, ok);
      check("ovf_accept", 32'(ok), 32'd1);
      check("ovf_flag", 32'(overflow), 32'd1);
      check("ovf_rdy", 32'(in_ready), 32'd0);
      repeat (6) @(negedge clock);
      check("ovf_wc", 32'(write_complete), 32'd0);
      check("ovf_hold", 32'(overflow), 32'd1);
      r = {};
      for (int i = 0; i < 244; i += 4)
         r.push_back({m[i], m[i+1], m[i+2], m[i+3]});
      check_writes("ovf", base, r);
      start = 1'b0;
      @(negedge clock);
      @(negedge clock);
      check("ovf_clear", 32'(overflow), 32'd0);

      @(negedge clock);
      start = 1'b1;
      send(rand_msg(5), 1'b0, 0, ok);
      check("drop_accept", 32'(ok), 32'd1);
      start = 1'b0;
      @(negedge clock);
      check("drop_rdy", 32'(in_ready), 32'd0);
      check("drop_we", 32'(write_enable), 32'd0);
      check("drop_addr", 32'(write_address), 32'd0);
      check("drop_data", write_data, 32'd0);
      check("drop_wc", 32'(write_complete), 32'd0);
      check("drop_ovf", 32'(overflow), 32'd0);
      m = {8'h61, 8'h62, 8'h63};
      run_msg("abc_rerun", m, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               compared, mismatched);
      $finish;
   end

endmodule
